// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: clock sequencer for the CPU core.
// Turns a raw step pushbutton into exactly one single-cycle CPU enable per
// press (2-flop synchronizer plus press/release debounce). A free-run mode
// issues an enable every RUN_DIV cycles while run_sw is high.
// Optional feature macro: CPU_STEP_BREAKPOINT_EN. When defined, free-run
// halts in BREAK before issuing an enable at pc == bp_addr. The first enable
// after entering RUN skips the compare, so resuming steps past the breakpoint.
// When the macro is undefined, pc and bp_addr are unused and halted is 0.
module cpu_step_ctrl #(
  parameter int PC_W            = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_step,
  input  logic            run_sw,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] bp_addr,
  output logic            cpu_en,
  output logic [15:0]     step_count,
  output logic            halted,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    DEBOUNCE     = 3'd1,
    STEP         = 3'd2,
    WAIT_RELEASE = 3'd3,
    RUN          = 3'd4,
    BREAK        = 3'd5
  } state_t;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_t           fsm_state;
  state_t           fsm_next;
  logic             btn_meta;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             resume;
  logic             resume_next;
  logic             bp_hit;

`ifdef CPU_STEP_BREAKPOINT_EN
  // The first enable after entering RUN never matches, so a resume advances.
  assign bp_hit = !resume && (pc == bp_addr);
`else
  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{pc, bp_addr};
  assign bp_hit = 1'b0;
`endif

  assign state = fsm_state;

  // Two-flop synchronizer bringing the asynchronous pushbutton into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_step;
      btn_s    <= btn_meta;
    end
  end

  // Next-state, counter/divider updates and output decode. Besides the
  // registered state and divider, only the run_sw level and the breakpoint
  // match gate the free-run enable, so a dropped switch never leaks a pulse.
  always_comb begin
    fsm_next    = fsm_state;
    cnt_next    = cnt;
    div_next    = div;
    resume_next = resume;
    cpu_en      = 1'b0;
    halted      = 1'b0;
    case (fsm_state)
      IDLE: begin
        if (run_sw) begin
          fsm_next    = RUN;
          div_next    = '0;
          resume_next = 1'b1;
        end else if (btn_s) begin
          fsm_next = DEBOUNCE;
          cnt_next = '0;
        end
      end
      DEBOUNCE: begin
        if (!btn_s) begin
          fsm_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          fsm_next = STEP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STEP: begin
        cpu_en   = 1'b1;
        fsm_next = WAIT_RELEASE;
        cnt_next = '0;
      end
      WAIT_RELEASE: begin
        if (btn_s) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          fsm_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!run_sw) begin
          fsm_next = IDLE;
        end else begin
          div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
          if (div == DIV_LAST) begin
            if (bp_hit) begin
              fsm_next = BREAK;
            end else begin
              cpu_en      = 1'b1;
              resume_next = 1'b0;
            end
          end
        end
      end
      BREAK: begin
`ifdef CPU_STEP_BREAKPOINT_EN
        halted = 1'b1;
`endif
        if (!run_sw) begin
          fsm_next = IDLE;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  // State, debounce counter, divider, resume flag and pulse counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state  <= IDLE;
      cnt        <= '0;
      div        <= '0;
      resume     <= 1'b0;
      step_count <= 16'd0;
    end else begin
      fsm_state  <= fsm_next;
      cnt        <= cnt_next;
      div        <= div_next;
      resume     <= resume_next;
      step_count <= step_count + {15'd0, cpu_en};
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=3).
// Stimulus pushes each expected cpu_en pulse (edge number and step_count)
// into a queue; a negedge monitor pops and compares whenever cpu_en is high
// and reports any expected pulse whose cycle passes without one.
module tb_cpu_step_ctrl;

  localparam int PC_W = 10;

  typedef struct {
    int cyc;
    int cnt;
  } pulse_t;

  logic            clk;
  logic            rst;
  logic            btn_step;
  logic            run_sw;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] bp_addr;
  logic            cpu_en;
  logic [15:0]     step_count;
  logic            halted;
  logic [2:0]      state;

  int     cyc;
  int     nvec;
  int     nfail;
  int     exp_count;
  int     k;
  pulse_t exp_q[$];

  cpu_step_ctrl #(
    .PC_W(PC_W),
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_step(btn_step),
    .run_sw(run_sw),
    .pc(pc),
    .bp_addr(bp_addr),
    .cpu_en(cpu_en),
    .step_count(step_count),
    .halted(halted),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter and a minimal CPU model whose PC advances on each enable.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) pc <= '0;
    else if (cpu_en) pc <= pc + 1'b1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL pulse_unexpected: cpu_en=1 at edge %0d, required no pulse", cyc);
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || int'(step_count) != e.cnt) begin
          nfail++;
          $display("FAIL pulse: edge %0d step_count %0d, required edge %0d step_count %0d",
                   cyc, step_count, e.cyc, e.cnt);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      pulse_t e;
      e = exp_q.pop_front();
      nvec++;
      nfail++;
      $display("FAIL pulse_missing: cpu_en=%b at edge %0d, required 1 at edge %0d",
               cpu_en, cyc, e.cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Advance n active edges, then settle just after the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int c);
    pulse_t e;
    e.cyc = c;
    e.cnt = exp_count;
    exp_q.push_back(e);
    exp_count = (exp_count + 1) & 16'hFFFF;
  endtask

  task automatic press(input int hold, input int rel);
    k = cyc;
    btn_step = 1'b1;
    expect_pulse(k + 7);
    cycles(hold);
    btn_step = 1'b0;
    cycles(rel);
  endtask

  initial begin
    cyc = 0; nvec = 0; nfail = 0; exp_count = 0;
    pc = '0;
    bp_addr = '1;
    rst = 1'b1; btn_step = 1'b1; run_sw = 1'b0;

    // 1. Reset with inputs toggling.
    cycles(1);
    btn_step = 1'b0; run_sw = 1'b1;
    cycles(1);
    rst = 1'b0; run_sw = 1'b0;
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_halted", halted, 0);
    chk("reset_step_count", step_count, 0);

    // 2. Bounce: two cycles high is rejected.
    cycles(1);
    btn_step = 1'b1;
    cycles(2);
    btn_step = 1'b0;
    cycles(1);
    @(negedge clk);
    chk("bounce_debounce_state", state, 1);
    cycles(9);
    @(negedge clk);
    chk("bounce_state", state, 0);
    chk("bounce_step_count", step_count, 0);

    // 3. Two clean presses, one pulse each.
    cycles(1);
    k = cyc;
    btn_step = 1'b1;
    expect_pulse(k + 7);
    cycles(15);
    @(negedge clk);
    chk("held_wait_release_state", state, 3);
    cycles(5);
    btn_step = 1'b0;
    cycles(10);
    @(negedge clk);
    chk("press1_state", state, 0);
    chk("press1_step_count", step_count, 1);
    cycles(1);
    press(20, 10);
    @(negedge clk);
    chk("press2_state", state, 0);
    chk("press2_step_count", step_count, 2);

    // 4. Free-run for 31 cycles: 10 pulses, 3 apart.
    cycles(1);
    k = cyc;
    run_sw = 1'b1;
    for (int j = 0; j < 10; j++) expect_pulse(k + 3 + 3 * j);
    cycles(2);
    @(negedge clk);
    chk("run_state", state, 4);
    cycles(29);
    run_sw = 1'b0;
    @(negedge clk);
    chk("run_last_state", state, 4);
    cycles(1);
    @(negedge clk);
    chk("run_exit_state", state, 0);
    chk("run_step_count", step_count, 12);
    cycles(5);

    // 6a. Reset during RUN.
    k = cyc;
    run_sw = 1'b1;
    expect_pulse(k + 3);
    cycles(4);
    rst = 1'b1; run_sw = 1'b0;
    exp_count = 0;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run_state", state, 0);
    chk("rst_run_cpu_en", cpu_en, 0);
    chk("rst_run_step_count", step_count, 0);
    cycles(20);

    // 6b. Reset during DEBOUNCE, then a full press still works.
    k = cyc;
    btn_step = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("rst_deb_pre_state", state, 1);
    cycles(1);
    rst = 1'b1; btn_step = 1'b0;
    exp_count = 0;
    cycles(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_deb_state", state, 0);
    chk("rst_deb_cpu_en", cpu_en, 0);
    chk("rst_deb_step_count", step_count, 0);
    cycles(20);
    press(12, 10);
    @(negedge clk);
    chk("after_rst_press_step_count", step_count, 1);
    chk("after_rst_press_state", state, 0);

`ifdef CPU_STEP_BREAKPOINT_EN
    // 5. Breakpoint at pc=5, then resume past it.
    cycles(1);
    rst = 1'b1;
    exp_count = 0;
    cycles(1);
    rst = 1'b0;
    bp_addr = 10'd5;
    k = cyc;
    run_sw = 1'b1;
    for (int j = 0; j < 5; j++) expect_pulse(k + 3 + 3 * j);
    cycles(20);
    @(negedge clk);
    chk("bp_state", state, 5);
    chk("bp_halted", halted, 1);
    chk("bp_step_count", step_count, 5);
    chk("bp_pc", pc, 5);
    cycles(4);
    run_sw = 1'b0;
    cycles(1);
    @(negedge clk);
    chk("bp_exit_state", state, 0);
    chk("bp_exit_halted", halted, 0);
    cycles(1);
    k = cyc;
    run_sw = 1'b1;
    expect_pulse(k + 3);
    expect_pulse(k + 6);
    cycles(7);
    run_sw = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("resume_state", state, 0);
    chk("resume_pc", pc, 7);
    chk("resume_step_count", step_count, 7);
`endif

    cycles(5);
    chk("pending_pulses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
